// File: rtl/kamus_div_seq.sv
// kamus_div_seq
// Iterative divide sequencer for DIV, DIVU, REM and REMU. Decode steers divide
// ops here instead of the single-cycle ALU. While a radix-2^BITS_PER_CYCLE
// restoring division runs, the pipeline is held. The result then returns with
// the destination tag captured at accept.
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       synchronous active-high reset
//   start_i     divide request, taken only while ready_o=1
//   op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data_i  dividend
//   rs2_data_i  divisor
//   tag_i       destination register tag
//   flush_i     abort any operation in flight
//   ready_o     idle and able to accept
//   stall_o     hold upstream stages
//   done_o      one-cycle pulse, result_o/tag_o valid
//   result_o    quotient or remainder, held until the next finalise
//   tag_o       tag of the finalised operation
//
// BITS_PER_CYCLE must be 1, 2 or 4 and must divide XLEN.
module kamus_div_seq #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [XLEN-1:0]  rs1_data_i,
   input  logic [XLEN-1:0]  rs2_data_i,
   input  logic [TAG_W-1:0] tag_i,
   input  logic             flush_i,
   output logic             ready_o,
   output logic             stall_o,
   output logic             done_o,
   output logic [XLEN-1:0]  result_o,
   output logic [TAG_W-1:0] tag_o
);

   localparam int ITER  = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   rem_q;
   logic [XLEN-1:0]   quo_q;
   logic [XLEN-1:0]   div_q;
   logic              sel_rem_q;
   logic              neg_quo_q;
   logic              neg_rem_q;
   logic [TAG_W-1:0]  tag_lat_q;
   logic [XLEN-1:0]   result_q;
   logic [TAG_W-1:0]  tag_q;

   logic              accept;
   logic              is_signed;
   logic              rs1_neg;
   logic              rs2_neg;
   logic [XLEN-1:0]   rs1_mag;
   logic [XLEN-1:0]   rs2_mag;
   logic              div_zero;
   logic              overflow;
   logic [XLEN-1:0]   special_res;

   logic [XLEN-1:0]   step_rem;
   logic [XLEN-1:0]   step_quo;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     trial;
   logic [XLEN-1:0]   fin_quo;
   logic [XLEN-1:0]   fin_rem;

   // Status outputs are pure decodes of the state. stall_o also rises in the
   // accept cycle, so the requesting instruction holds in place without a
   // bubble.
   assign accept   = (state_q == IDLE) && start_i && !flush_i;
   assign ready_o  = (state_q == IDLE);
   assign stall_o  = (state_q == CALC) || accept;
   assign done_o   = (state_q == DONE);
   assign result_o = result_q;
   assign tag_o    = tag_q;

   // Operand preparation at accept. For signed ops the magnitude is a plain
   // two's complement negate, so the most negative value stays 0x80..0. Read
   // as unsigned, that is already the right magnitude.
   always_comb begin
      is_signed   = !op_i[0];
      rs1_neg     = is_signed && rs1_data_i[XLEN-1];
      rs2_neg     = is_signed && rs2_data_i[XLEN-1];
      rs1_mag     = rs1_neg ? (~rs1_data_i + 1'b1) : rs1_data_i;
      rs2_mag     = rs2_neg ? (~rs2_data_i + 1'b1) : rs2_data_i;
      div_zero    = (rs2_data_i == '0);
      overflow    = is_signed && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = op_i[1] ? rs1_data_i : '1;
      end else begin
         special_res = op_i[1] ? '0 : MIN_NEG;
      end
   end

   // BITS_PER_CYCLE restoring steps, chained within one cycle. The shifted
   // partial remainder can reach 2*divisor-1, so the trial subtract is one bit
   // wider than XLEN. The top bit of the trial is then a true sign.
   always_comb begin
      step_rem = rem_q;
      step_quo = quo_q;
      shifted  = '0;
      trial    = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         shifted  = {step_rem, step_quo[XLEN-1]};
         step_quo = {step_quo[XLEN-2:0], 1'b0};
         trial    = shifted - {1'b0, div_q};
         if (!trial[XLEN]) begin
            step_rem    = trial[XLEN-1:0];
            step_quo[0] = 1'b1;
         end else begin
            step_rem    = shifted[XLEN-1:0];
         end
      end
      fin_quo = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
      fin_rem = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
   end

   // Sequencer FSM. result/tag outputs change only on a finalise: either a
   // special case resolved at accept, or the last CALC step. An aborted
   // operation therefore never disturbs the previous result.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         div_q     <= '0;
         sel_rem_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         tag_lat_q <= '0;
         result_q  <= '0;
         tag_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sel_rem_q <= op_i[1];
                  neg_quo_q <= rs1_neg ^ rs2_neg;
                  neg_rem_q <= rs1_neg;
                  tag_lat_q <= tag_i;
                  rem_q     <= '0;
                  quo_q     <= rs1_mag;
                  div_q     <= rs2_mag;
                  cnt_q     <= '0;
                  if (div_zero || overflow) begin
                     result_q <= special_res;
                     tag_q    <= tag_i;
                     state_q  <= DONE;
                  end else begin
                     state_q  <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush_i) begin
                  state_q <= IDLE;
               end else begin
                  rem_q <= step_rem;
                  quo_q <= step_quo;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) begin
                     result_q <= sel_rem_q ? fin_rem : fin_quo;
                     tag_q    <= tag_lat_q;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/kamus_div_seq.md
Name: kamus_div_seq

Overview:
- Iterative divide sequencer for the M-extension ops DIV, DIVU, REM and REMU.
- Sits beside kamus_EX. Decode steers divide ops here instead of the single-cycle ALU.
- Holds the pipeline through stall_o while a radix-2^BITS_PER_CYCLE restoring division runs.
- Returns the result with the captured destination tag for the EX/MEM register.

Parameters:
- XLEN, 32, operand and result width.
- BITS_PER_CYCLE, 1, quotient bits retired per CALC cycle. Legal values: 1, 2, 4. Must divide XLEN.
- TAG_W, 5, destination register tag width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  request a divide. Accepted only when ready_o=1.
- op_i  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_data_i  in  XLEN  dividend.
- rs2_data_i  in  XLEN  divisor.
- tag_i  in  TAG_W  destination register tag.
- flush_i  in  1  abort any operation in flight.
- ready_o  out  1  sequencer idle and able to accept.
- stall_o  out  1  hold upstream stages.
- done_o  out  1  one-cycle pulse: result_o and tag_o are valid.
- result_o  out  XLEN  quotient or remainder.
- tag_o  out  TAG_W  tag captured at accept.

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; ready_o=1; stall_o=0; done_o=0; result_o=0; tag_o=0; internal counter and registers cleared.
- Reset has priority over every other input, including mid-operation. No done_o follows a reset.

- FSM states:
  - IDLE -> CALC on accept of a normal case.
  - IDLE -> DONE on accept of a special case.
  - CALC -> DONE when the iteration counter reaches XLEN/BITS_PER_CYCLE-1.
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE if flush_i=1.

- Accept: start_i=1, state IDLE and flush_i=0 at the same edge.
  - Latch op, tag and operand magnitudes.
  - For signed ops: |x| = two's complement negate when the MSB is set. |0x80000000| = 0x80000000 as unsigned.
  - Latch neg_q = sign(rs1) XOR sign(rs2), signed ops only.
  - Latch neg_r = sign(rs1), signed ops only.

- Output decode:
  - ready_o = (state==IDLE).
  - stall_o = (state==CALC) OR (state==IDLE AND start_i AND NOT flush_i).
  - This lets the requesting instruction stall in its own accept cycle.
  - done_o = (state==DONE).

- CALC step, repeated BITS_PER_CYCLE times per cycle:
  - Shift {rem, quo} left by one.
  - Trial = rem - divisor, computed XLEN+1 bits wide.
  - If trial is non-negative: rem = trial, quo LSB = 1. Otherwise quo LSB = 0.
  - Counter increments once per cycle.

- Finalise, on the CALC->DONE edge:
  - Quotient = neg_q ? -quo : quo.
  - Remainder = neg_r ? -rem : rem.
  - result_o takes the quotient for DIV/DIVU and the remainder for REM/REMU.

- Special cases, resolved at accept; result registered directly, no CALC:
  - Divisor 0: quotient = all ones; remainder = rs1 unmodified. Applies to all four ops.
  - Signed overflow (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.

- Latency from the accept edge to the done_o pulse:
  - Normal case: XLEN/BITS_PER_CYCLE + 1 cycles (33 at defaults).
  - Special case: 1 cycle.

- result_o and tag_o hold their values after done_o until the next finalise. They are not cleared on IDLE.
- start_i is ignored while ready_o=0. Requesters must hold it until accepted.
- Back-to-back: the earliest next accept is the cycle after DONE.

- Flush:
  - flush_i=1 in CALC or DONE: next state IDLE. No done_o in the following cycle, even if flush arrives during the DONE cycle; done_o already high in that cycle stays high, since it is combinational from state.
  - flush_i=1 together with start_i in IDLE: request not accepted.
  - result_o is not updated by an aborted operation.

Test Plan:
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> done_o exactly 33 cycles after accept; result_o=0xFFFFFFFD, tag_o=tag_i; stall_o high on the accept cycle and all 32 CALC cycles; ready_o low until after DONE.
- REM -7,2 -> 0xFFFFFFFF. REMU 0xFFFFFFF9,2 -> 0x00000001. DIVU 0xFFFFFFFF,0x10 -> 0x0FFFFFFF.
- Divisor zero: DIV 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 0x00000005. Each gives done_o 1 cycle after accept and never enters CALC.
- Overflow: DIV 0x80000000,0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000, 1-cycle latency. DIV 0x80000000,1 -> 0x80000000 via the normal 33-cycle path.
- Flush at CALC cycle 10 -> no done_o, ready_o=1 next cycle, result_o unchanged. An immediate DIVU 100,7 then yields 14 after 33 cycles. Repeat with rst_i in place of flush: all outputs reset.
- BITS_PER_CYCLE=4 build: random signed and unsigned operands checked against a reference model; latency exactly 9 cycles; start_i held during busy is ignored.
